// File: rtl/msi_snoop_bus_responder.sv
// Shared-bus responder for a two-core MSI system: serialises write-backs and
// miss/invalidate requests, snoops the other core, and fills from memory.
module msi_snoop_bus_responder #(
  parameter int unsigned MEM_LATENCY    = 2,
  parameter logic [1:0]  BUS_INVALIDATE = 2'b00,
  parameter logic [1:0]  BUS_WRITE_MISS = 2'b01,
  parameter logic [1:0]  BUS_READ_MISS  = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [3:0]  req_type,
  input  logic [19:0] req_addr,
  input  logic [1:0]  wb_valid,
  input  logic [19:0] wb_addr,
  input  logic [63:0] wb_data,
  input  logic [1:0]  snoop_found,
  input  logic [63:0] snoop_data,
  output logic [1:0]  snoop_valid,
  output logic [1:0]  snoop_type,
  output logic [8:0]  snoop_addr,
  output logic [1:0]  resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_from_cache,
  output logic [1:0]  wb_ack
);

  typedef enum logic [1:0] {IDLE, SNOOP, MEM_WAIT, RESPOND} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state, state_nxt;
  logic        rr;
  logic        core_q;
  logic [1:0]  type_q;
  logic [9:0]  addr_q;
  logic [31:0] data_q;
  logic        from_cache_q;
  logic [3:0]  cnt;

  logic [31:0] mem [1024] = '{default: '0};

  logic        wb_sel, req_sel, grant, is_miss, found;
  logic [9:0]  wb_addr_sel, req_addr_sel;
  logic [31:0] wb_data_sel, other_data;
  logic [1:0]  req_type_sel, wb_ack_int;
  logic        mem_we;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_wdata;

  // Only a genuine tie consults the pointer; a lone strobe wins outright.
  function automatic logic pick(input logic [1:0] v, input logic ptr);
    return (v == 2'b11) ? ptr : v[1];
  endfunction

  assign wb_sel       = pick(wb_valid, rr);
  assign req_sel      = pick(req_valid, rr);
  assign wb_addr_sel  = wb_sel ? wb_addr[19:10] : wb_addr[9:0];
  assign wb_data_sel  = wb_sel ? wb_data[63:32] : wb_data[31:0];
  assign req_addr_sel = req_sel ? req_addr[19:10] : req_addr[9:0];
  assign req_type_sel = req_sel ? req_type[3:2] : req_type[1:0];

  assign is_miss    = (type_q == BUS_WRITE_MISS) || (type_q == BUS_READ_MISS);
  assign found      = core_q ? snoop_found[0] : snoop_found[1];
  assign other_data = core_q ? snoop_data[31:0] : snoop_data[63:32];

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    wb_ack_int = '0;
    mem_we     = 1'b0;
    mem_waddr  = addr_q;
    mem_wdata  = other_data;
    case (state)
      IDLE: begin
        if (wb_valid != 2'b00) begin
          mem_we             = 1'b1;
          mem_waddr          = wb_addr_sel;
          mem_wdata          = wb_data_sel;
          wb_ack_int[wb_sel] = 1'b1;
        end else if (req_valid != 2'b00) begin
          grant     = 1'b1;
          state_nxt = SNOOP;
        end
      end
      SNOOP: begin
        if (!is_miss) begin
          state_nxt = RESPOND;
        end else if (found) begin
          mem_we    = 1'b1;
          state_nxt = RESPOND;
        end else begin
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: if (cnt == '0) state_nxt = RESPOND;
      RESPOND:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    // State is already IDLE under reset, so the write-back path must be muted here.
    if (!rst_n) begin
      mem_we     = 1'b0;
      wb_ack_int = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr           <= 1'b0;
      core_q       <= 1'b0;
      type_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      from_cache_q <= 1'b0;
      cnt          <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant) begin
            core_q <= req_sel;
            type_q <= req_type_sel;
            addr_q <= req_addr_sel;
          end
        end
        SNOOP: begin
          if (!is_miss) begin
            data_q       <= '0;
            from_cache_q <= 1'b0;
          end else if (found) begin
            data_q       <= other_data;
            from_cache_q <= 1'b1;
          end else begin
            // No writes can land while busy, so sampling memory now is equivalent.
            data_q       <= mem[addr_q];
            from_cache_q <= 1'b0;
            cnt          <= WAIT_INIT;
          end
        end
        MEM_WAIT: if (cnt != '0) cnt <= cnt - 4'd1;
        RESPOND:  rr <= ~core_q;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign snoop_valid     = (state == SNOOP) ? (core_q ? 2'b01 : 2'b10) : 2'b00;
  assign snoop_type      = type_q;
  assign snoop_addr      = addr_q[8:0];
  assign resp_valid      = (state == RESPOND) ? (core_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_data       = (state == RESPOND) ? data_q : '0;
  assign resp_from_cache = (state == RESPOND) && from_cache_q;
  assign wb_ack          = wb_ack_int;

endmodule

// File: tb/tb_msi_snoop_bus_responder.sv
// Scoreboard bench for msi_snoop_bus_responder: expected snoops and responses
// (with due cycle) are queued at stimulus time and checked as the DUT emits them.
module tb_msi_snoop_bus_responder;

  localparam int unsigned MEM_LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [3:0]  req_type;
  logic [19:0] req_addr;
  logic [1:0]  wb_valid;
  logic [19:0] wb_addr;
  logic [63:0] wb_data;
  logic [1:0]  snoop_found;
  logic [63:0] snoop_data;
  logic [1:0]  snoop_valid;
  logic [1:0]  snoop_type;
  logic [8:0]  snoop_addr;
  logic [1:0]  resp_valid;
  logic [31:0] resp_data;
  logic        resp_from_cache;
  logic [1:0]  wb_ack;

  msi_snoop_bus_responder #(.MEM_LATENCY(MEM_LATENCY)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .snoop_found(snoop_found), .snoop_data(snoop_data),
    .snoop_valid(snoop_valid), .snoop_type(snoop_type), .snoop_addr(snoop_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_from_cache(resp_from_cache),
    .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] data;
    logic        fc;
    int unsigned due;
  } resp_t;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  typ;
    logic [8:0]  addr;
    int unsigned due;
  } snp_t;

  resp_t       rq[$];
  snp_t        snq[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (snoop_valid != 2'b00) begin
        if (snq.size() == 0) begin
          check("snoop_unexpected", 32'(snoop_valid), 32'd0);
        end else begin
          snp_t s;
          s = snq.pop_front();
          check("snoop_valid", 32'(snoop_valid), 32'(s.valid));
          check("snoop_type", 32'(snoop_type), 32'(s.typ));
          check("snoop_addr", 32'(snoop_addr), 32'(s.addr));
          check("snoop_cycle", cyc, s.due);
        end
      end
      if (resp_valid != 2'b00) begin
        if (rq.size() == 0) begin
          check("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          resp_t e;
          e = rq.pop_front();
          check("resp_valid", 32'(resp_valid), 32'(e.valid));
          check("resp_data", resp_data, e.data);
          check("resp_from_cache", 32'(resp_from_cache), 32'(e.fc));
          check("resp_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic wait_resp(input int core);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid[core]) seen = 1;
    end
    if (!seen) check("resp_timeout", 32'(resp_valid), 32'(1 << core));
    req_valid[core] = 1'b0;
  endtask

  task automatic push_exp(input int core, input logic [1:0] typ, input logic [9:0] addr,
                          input int unsigned grant_cyc, input int unsigned lat,
                          input logic [31:0] data, input logic fc);
    snq.push_back('{valid: (core == 1) ? 2'b01 : 2'b10, typ: typ, addr: addr[8:0],
                    due: grant_cyc + 1});
    rq.push_back('{valid: (core == 1) ? 2'b10 : 2'b01, data: data, fc: fc,
                   due: grant_cyc + lat});
  endtask

  task automatic do_req(input int core, input logic [1:0] typ, input logic [9:0] addr,
                        input logic found, input logic [31:0] sdata,
                        input logic [31:0] exp_data, input logic exp_fc);
    bit miss;
    @(posedge clk); #1;
    req_valid[core]           = 1'b1;
    req_type[core*2 +: 2]     = typ;
    req_addr[core*10 +: 10]   = addr;
    snoop_found               = '0;
    snoop_found[1-core]       = found;
    snoop_data[(1-core)*32 +: 32] = sdata;
    miss = (typ == 2'b01) || (typ == 2'b10);
    push_exp(core, typ, addr, cyc, (miss && !found) ? MEM_LATENCY + 2 : 2, exp_data, exp_fc);
    wait_resp(core);
    snoop_found = '0;
  endtask

  task automatic do_wb(input int core, input logic [9:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    wb_valid[core]            = 1'b1;
    wb_addr[core*10 +: 10]    = addr;
    wb_data[core*32 +: 32]    = data;
    @(negedge clk);
    check("wb_ack", 32'(wb_ack), 32'(1 << core));
    @(posedge clk); #1;
    wb_valid[core] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int unsigned d, r;
    rst_n = 1'b0; req_valid = '0; req_type = '0; req_addr = '0;
    wb_valid = 2'b01; wb_addr = '0; wb_data = '0; snoop_found = '0; snoop_data = '0;

    // Reset: all outputs low even with a write-back strobe present
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_snoop_valid", 32'(snoop_valid), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_wb_ack", 32'(wb_ack), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_misc", {21'd0, resp_from_cache, snoop_type, snoop_addr}, 32'd0);
    wb_valid = '0;
    rst_n = 1'b1;

    // Write-back then memory-sourced read miss
    do_wb(0, 10'h3A5, 32'hDEADBEEF);
    do_req(1, 2'b10, 10'h3A5, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);

    // Snoop-sourced read miss, then the snooped data is visible in memory
    do_req(0, 2'b10, 10'h010, 1'b1, 32'h12345678, 32'h12345678, 1'b1);
    do_req(1, 2'b10, 10'h010, 1'b0, 32'h0, 32'h12345678, 1'b0);

    // Invalidate ignores snoop data and leaves memory untouched
    do_req(1, 2'b00, 10'h07F, 1'b1, 32'hAAAA5555, 32'h0, 1'b0);
    do_req(0, 2'b10, 10'h07F, 1'b0, 32'h0, 32'h0, 1'b0);

    // Unknown code behaves as invalidate
    do_req(0, 2'b11, 10'h020, 1'b1, 32'hCAFEF00D, 32'h0, 1'b0);

    // Write misses from memory and from snoop
    do_req(0, 2'b01, 10'h030, 1'b0, 32'h0, 32'h0, 1'b0);
    do_req(1, 2'b01, 10'h030, 1'b1, 32'h0BADF00D, 32'h0BADF00D, 1'b1);

    // Simultaneous write-backs: pointer favours core0 after core1's completion
    @(posedge clk); #1;
    wb_valid = 2'b11;
    wb_addr  = {10'h200, 10'h100};
    wb_data  = {32'h22220000, 32'h11110000};
    @(negedge clk);
    check("wb_tie_first", 32'(wb_ack), 32'h1);
    @(posedge clk); #1;
    wb_valid[0] = 1'b0;
    @(negedge clk);
    check("wb_tie_second", 32'(wb_ack), 32'h2);
    @(posedge clk); #1;
    wb_valid[1] = 1'b0;

    // Both cores request together twice: core0, then core1, then core0 again
    @(posedge clk); #1;
    req_valid = 2'b11;
    req_type  = 4'b1010;
    req_addr  = {10'h200, 10'h100};
    snoop_found = '0;
    push_exp(0, 2'b10, 10'h100, cyc, MEM_LATENCY + 2, 32'h11110000, 1'b0);
    wait_resp(0);
    r = cyc;
    req_valid[0] = 1'b1;
    req_addr[9:0] = 10'h200;
    push_exp(1, 2'b10, 10'h200, r + 1, MEM_LATENCY + 2, 32'h22220000, 1'b0);
    wait_resp(1);
    r = cyc;
    push_exp(0, 2'b10, 10'h200, r + 1, MEM_LATENCY + 2, 32'h22220000, 1'b0);
    wait_resp(0);

    // Write-back and request in the same cycle: write-back first, grant next cycle
    @(posedge clk); #1;
    wb_valid[0] = 1'b1; wb_addr[9:0] = 10'h050; wb_data[31:0] = 32'h00000055;
    req_valid[1] = 1'b1; req_type[3:2] = 2'b10; req_addr[19:10] = 10'h050;
    d = cyc;
    push_exp(1, 2'b10, 10'h050, d + 1, MEM_LATENCY + 2, 32'h00000055, 1'b0);
    @(negedge clk);
    check("wb_over_req", 32'(wb_ack), 32'h1);
    @(posedge clk); #1;
    wb_valid[0] = 1'b0;
    wait_resp(1);

    // Reset during MEM_WAIT abandons the transaction
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_type[1:0] = 2'b10; req_addr[9:0] = 10'h100;
    snoop_found = '0;
    snq.push_back('{valid: 2'b10, typ: 2'b10, addr: 9'h100, due: cyc + 1});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_snoop_valid", 32'(snoop_valid), 32'd0);
    check("midrst_resp_data", resp_data, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);

    // Normal operation resumes; memory contents survive reset
    do_req(0, 2'b10, 10'h3A5, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req(1, 2'b10, 10'h030, 1'b0, 32'h0, 32'h0BADF00D, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sb_resp_empty", rq.size(), 32'd0);
    check("sb_snoop_empty", snq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
